// File: rtl/enc_pkg.sv
// Shared types for the ENC28J60 command path: SPI opcodes, ROM command word
// layout and the sequencer state encoding.
package enc_pkg;

  typedef enum logic [2:0] {
    RCR    = 3'b000,
    RBM    = 3'b001,
    WCR    = 3'b010,
    WBM    = 3'b011,
    BFS    = 3'b100,
    BFC    = 3'b101,
    PSEUDO = 3'b110,
    SRC    = 3'b111
  } enc_opcode_e;

  // PSEUDO with this address terminates the ROM program
  localparam logic [4:0] END_ADDR = 5'h1F;

  typedef struct packed {
    enc_opcode_e opcode;
    logic [4:0]  addr;
    logic [7:0]  data;
  } enc_cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_END,
    ST_GAP,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

  function automatic logic is_end_marker(input enc_cmd_t cmd);
    return (cmd.opcode == PSEUDO) && (cmd.addr == END_ADDR);
  endfunction

endpackage

// File: rtl/enc_down_counter.sv
// Loadable down counter that stops at zero; used for the SS gap, the DELAY
// pseudo-op and the transaction watchdog.
module enc_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: state is updated with non-blocking assignments only, and the reset
  // branch sits in the same always_ff so the async reset has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/enc_cmd_sequencer.sv
// Walks the init command ROM and issues one enc_driver transaction per word,
// with inter-command gap, DELAY/END pseudo-ops and a transaction watchdog.
module enc_cmd_sequencer
  import enc_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] LAST_ADDR   = 8'h9C,
  parameter int                GAP_CYCLES  = 4,
  parameter int                DELAY_SHIFT = 10,
  parameter int                TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_q,
  output logic              run_req,
  input  logic              end_flag,
  output logic [2:0]        opcode,
  output logic [4:0]        write_addr,
  output logic [7:0]        write_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] cmd_count
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int DLY_W = 8 + DELAY_SHIFT;

  seq_state_e state;
  enc_cmd_t   cmd_q;
  enc_cmd_t   rom_cmd;

  logic             gap_load, gap_dec, gap_zero;
  logic             wd_load, wd_dec, wd_zero;
  logic             dly_load, dly_dec, dly_zero;
  logic [DLY_W-1:0] dly_load_val;
  logic             is_pseudo, is_end, advance;

  assign rom_cmd   = enc_cmd_t'(rom_q);
  assign is_end    = is_end_marker(rom_cmd);
  assign is_pseudo = (rom_cmd.opcode == PSEUDO);

  // Counters are preloaded one short so that a state occupies exactly the
  // requested number of cycles and leaves on the cycle the count hits zero.
  assign gap_load = (state == ST_WAIT_END) && end_flag;
  assign gap_dec  = (state == ST_GAP);

  assign wd_load  = (state == ST_DECODE) && !is_pseudo;
  assign wd_dec   = (state == ST_ISSUE) || (state == ST_WAIT_END);

  assign dly_load = (state == ST_DECODE) && is_pseudo && !is_end;
  assign dly_dec  = (state == ST_DELAY);
  assign dly_load_val = (rom_cmd.data == 8'd0) ? '0
                      : (DLY_W'(rom_cmd.data) << DELAY_SHIFT) - DLY_W'(1);

  assign advance = ((state == ST_GAP) && gap_zero) ||
                   ((state == ST_DELAY) && dly_zero);

  enc_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_W'(GAP_CYCLES - 1)),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  enc_down_counter #(.W(WD_W)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (WD_W'(TIMEOUT)),
    .dec      (wd_dec),
    .zero     (wd_zero)
  );

  enc_down_counter #(.W(DLY_W)) u_delay_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_load_val),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      run_req   <= 1'b0;
      cmd_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cmd_count <= '0;
    end else begin
      run_req <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            rom_addr  <= '0;
            cmd_count <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (is_end) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (is_pseudo) begin
            state <= ST_DELAY;
          end else begin
            cmd_q   <= rom_cmd;
            run_req <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT_END;
        ST_WAIT_END: begin
          // a completion arriving on the expiry cycle still wins
          if (end_flag) begin
            if (cmd_count != '1) cmd_count <= cmd_count + ADDR_W'(1);
            state <= ST_GAP;
          end else if (wd_zero) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ST_ERROR;
          end
        end
        ST_GAP, ST_DELAY: begin
          if (advance) begin
            if (rom_addr == LAST_ADDR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign opcode     = cmd_q.opcode;
  assign write_addr = cmd_q.addr;
  assign write_data = cmd_q.data;

endmodule

// File: tb/tb_enc_cmd_sequencer.sv
// Directed bench for enc_cmd_sequencer: ROM model plus a hand-driven
// enc_driver handshake, expected timings computed by hand.
module tb_enc_cmd_sequencer;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_q;
  logic              run_req;
  logic              end_flag;
  logic [2:0]        opcode;
  logic [4:0]        write_addr;
  logic [7:0]        write_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] cmd_count;

  logic [15:0] rom [0:255];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  enc_cmd_sequencer #(
    .ADDR_W      (ADDR_W),
    .LAST_ADDR   (8'h03),
    .GAP_CYCLES  (4),
    .DELAY_SHIFT (10),
    .TIMEOUT     (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .run_req    (run_req),
    .end_flag   (end_flag),
    .opcode     (opcode),
    .write_addr (write_addr),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cmd_count  (cmd_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_rom(input logic [15:0] w0, w1, w2, w3);
    for (int i = 0; i < 256; i++) rom[i] = 16'h5FAA;
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
    rom[3] = w3;
  endtask

  task automatic pulse_start(output int t);
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req(input string tag, output int t);
    @(negedge clk);
    for (int i = 0; i < 3000 && !run_req; i++) @(negedge clk);
    check(tag, run_req, 1'b1);
    t = cyc;
  endtask

  // end_flag lands lat cycles after the cycle the caller is in
  task automatic pulse_end(input int lat, input logic [15:0] exp_word);
    repeat (lat) @(negedge clk);
    check("hold_word", {opcode, write_addr, write_data}, exp_word);
    end_flag = 1'b1;
    @(negedge clk);
    end_flag = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check(tag, busy, 1'b0);
  endtask

  int ts, t1, t2, te, n_req;
  logic [15:0] t3_words [4];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    end_flag = 1'b0;
    load_rom(16'h5F03, 16'h4F0C, 16'hDF00, 16'h5FAA);
    repeat (3) @(negedge clk);
    check("rst_outputs", {run_req, busy, done, error}, 4'b0000);
    check("rst_rom_addr", rom_addr, 8'h00);
    check("rst_word", {opcode, write_addr, write_data}, 16'h0000);
    check("rst_cmd_count", cmd_count, 8'h00);
    rst = 1'b0;

    // two WCRs then END; spurious start/end_flag during the first gap
    pulse_start(ts);
    check("t1_busy", busy, 1'b1);
    wait_req("t1_req0", t1);
    check("t1_lat_start", t1 - ts, 3);
    check("t1_word0", {opcode, write_addr, write_data}, 16'h5F03);
    @(negedge clk);
    check("t1_req_single", run_req, 1'b0);
    pulse_end(19, 16'h5F03);
    end_flag = 1'b1;
    start = 1'b1;
    @(negedge clk);
    end_flag = 1'b0;
    start = 1'b0;
    check("t1_cnt_gap", cmd_count, 8'd1);
    wait_req("t1_req1", t2);
    check("t1_lat_gap", t2 - t1, 27);
    check("t1_word1", {opcode, write_addr, write_data}, 16'h4F0C);
    pulse_end(20, 16'h4F0C);
    wait_idle("t1_idle");
    check("t1_done_err", {done, error}, 2'b10);
    check("t1_cmd_count", cmd_count, 8'd2);
    check("t1_rom_addr", rom_addr, 8'h02);

    // DELAY of 2 << 10 cycles between commands
    load_rom(16'h5F03, 16'hC002, 16'h4F0C, 16'hDF00);
    pulse_start(ts);
    check("t2_done_clr", done, 1'b0);
    wait_req("t2_req0", t1);
    pulse_end(20, 16'h5F03);
    wait_req("t2_req1", t2);
    check("t2_lat_delay", t2 - t1, 2077);
    check("t2_word1", {opcode, write_addr, write_data}, 16'h4F0C);
    pulse_end(20, 16'h4F0C);
    wait_idle("t2_idle");
    check("t2_done", done, 1'b1);
    check("t2_cmd_count", cmd_count, 8'd2);
    check("t2_rom_addr", rom_addr, 8'h03);

    // no END marker: stops after LAST_ADDR
    t3_words[0] = 16'h5F01;
    t3_words[1] = 16'h4F02;
    t3_words[2] = 16'h5F03;
    t3_words[3] = 16'h4F04;
    load_rom(t3_words[0], t3_words[1], t3_words[2], t3_words[3]);
    pulse_start(ts);
    for (int k = 0; k < 4; k++) begin
      wait_req("t3_req", t1);
      check("t3_word", {opcode, write_addr, write_data}, t3_words[k]);
      pulse_end(5, t3_words[k]);
    end
    wait_idle("t3_idle");
    check("t3_done", done, 1'b1);
    check("t3_cmd_count", cmd_count, 8'd4);
    n_req = 0;
    repeat (20) begin
      @(negedge clk);
      if (run_req) n_req++;
    end
    check("t3_no_req", n_req, 0);
    check("t3_rom_addr", rom_addr, 8'h03);

    // watchdog expiry, then rerun with end_flag on the expiry cycle
    load_rom(16'h5F03, 16'hDF00, 16'h5FAA, 16'h5FAA);
    pulse_start(ts);
    wait_req("t4_req0", t1);
    for (int i = 0; i < 200 && !error; i++) @(negedge clk);
    te = cyc;
    check("t4_error", error, 1'b1);
    check("t4_err_lat", te - t1, 65);
    check("t4_busy_done", {busy, done}, 2'b00);
    pulse_start(ts);
    check("t4_err_clr", {busy, error}, 2'b10);
    wait_req("t4_req1", t1);
    check("t4_relat", t1 - ts, 3);
    check("t4_rom_addr0", rom_addr, 8'h00);
    check("t4_word", {opcode, write_addr, write_data}, 16'h5F03);
    pulse_end(64, 16'h5F03);
    wait_idle("t4_idle");
    check("t4_edge_ok", {done, error}, 2'b10);
    check("t4_cmd_count", cmd_count, 8'd1);

    // reset while waiting on the second command
    load_rom(16'h5F03, 16'h4F0C, 16'hDF00, 16'h5FAA);
    pulse_start(ts);
    wait_req("t5_req0", t1);
    pulse_end(10, 16'h5F03);
    wait_req("t5_req1", t2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_flags", {run_req, busy, done, error}, 4'b0000);
    check("t5_rst_addr", rom_addr, 8'h00);
    check("t5_rst_word", {opcode, write_addr, write_data}, 16'h0000);
    check("t5_rst_count", cmd_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    end_flag = 1'b1;
    @(negedge clk);
    end_flag = 1'b0;
    n_req = 0;
    repeat (10) begin
      @(negedge clk);
      if (run_req) n_req++;
    end
    check("t5_no_req", n_req, 0);
    check("t5_idle", {busy, done, error}, 3'b000);
    check("t5_count", cmd_count, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
